// File: rtl/cpu_trace_pkg.sv
// Shared types and defaults for the CPU run controller / trace buffer.
package cpu_trace_pkg;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [5:0] HALT_OP_DEF = 6'b111111;

  function automatic int entryWidth(input int pcW, input int insnW);
    return pcW + insnW;
  endfunction
endpackage

// File: rtl/cpu_run_tracer_trace_ring.sv
// trace_ring: circular DEPTH-entry buffer with a registered head word.
// A push into a full buffer without a pop overwrites the oldest entry.
module trace_ring
  import cpu_trace_pkg::*;
#(
  parameter int W     = 64,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wrData,
  output logic [W-1:0]  head,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty
);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE      = (AW+1)'(1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wrPtr, rdPtr, rdPtrNxt;
  logic [AW:0]   levelNxt;
  logic [W-1:0]  headNxt;
  logic          doPop, dropOld;

  assign empty    = (level == '0);
  assign full     = (level == FULL_LVL);
  assign doPop    = pop & ~empty;
  assign dropOld  = push & full & ~doPop;
  assign rdPtrNxt = rdPtr + AW'(doPop | dropOld);

  always_comb begin
    levelNxt = level;
    if (push && !doPop && !full) levelNxt = level + ONE;
    else if (!push && doPop)     levelNxt = level - ONE;
    // Head must track the slot being written when it becomes the new head.
    headNxt = head;
    if (levelNxt != '0) begin
      if (push && rdPtrNxt == wrPtr) headNxt = wrData;
      else                           headNxt = mem[rdPtrNxt];
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clr) mem[wrPtr] <= wrData;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      level <= '0;
      head  <= '0;
    end else if (clr) begin
      wrPtr <= '0;
      rdPtr <= '0;
      level <= '0;
      head  <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + AW'(1);
      rdPtr <= rdPtrNxt;
      level <= levelNxt;
      head  <= headNxt;
    end
  end
endmodule

// File: rtl/cpu_run_tracer.sv
// Run controller + execution trace for the single-cycle CPU.
// Optional macro TRACE_STALL_ON_FULL_EN: stall the CPU instead of overwriting when the trace is full.
module cpu_run_tracer
  import cpu_trace_pkg::*;
#(
  parameter int         PC_W       = 32,
  parameter int         INSN_W     = 32,
  parameter int         DEPTH      = 16,
  parameter int         MAX_CYCLES = 15,
  parameter logic [5:0] HALT_OP    = HALT_OP_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     step,
  input  logic                     halt_req,
  input  logic                     clr,
  input  logic [PC_W-1:0]          pc_in,
  input  logic [INSN_W-1:0]        instr_in,
  output logic                     cpu_en,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [PC_W-1:0]          rd_pc,
  output logic [INSN_W-1:0]        rd_instr,
  output logic [$clog2(DEPTH):0]   level,
  output logic [31:0]              cycles,
  output logic                     done,
  output logic                     overflow
);
  localparam int EW = entryWidth(PC_W, INSN_W);

  state_t        state, stateNxt;
  logic [EW-1:0] head;
  logic          full, empty, pop, stall, active, clrOk, budgetHit, haltCond;

  assign active = (state == S_RUN) || (state == S_STEP);
  assign pop    = rd_valid & rd_ready;
  assign clrOk  = clr & ((state == S_IDLE) || (state == S_DONE));

`ifdef TRACE_STALL_ON_FULL_EN
  assign stall = full & ~pop;
`else
  assign stall = 1'b0;
`endif

  assign cpu_en    = active & ~stall;
  assign budgetHit = (MAX_CYCLES != 0) && (({1'b0, cycles} + 33'd1) == 33'(MAX_CYCLES));
  // halt_req stops even a stalled run; opcode/budget only matter on an executed cycle.
  assign haltCond  = halt_req |
                     (cpu_en & ((instr_in[INSN_W-1 -: 6] == HALT_OP) | budgetHit));

  always_comb begin
    stateNxt = state;
    unique case (state)
      S_IDLE: if (start) stateNxt = S_RUN;
              else if (step) stateNxt = S_STEP;
      S_RUN:  if (haltCond) stateNxt = S_DONE;
      S_STEP: if (haltCond) stateNxt = S_DONE;
              else if (cpu_en) stateNxt = S_IDLE;
      S_DONE: if (clr) stateNxt = S_IDLE;
      default: stateNxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cycles   <= '0;
      overflow <= 1'b0;
    end else begin
      state <= stateNxt;
      if (clrOk) begin
        cycles   <= '0;
        overflow <= 1'b0;
      end else begin
        if (cpu_en && cycles != '1) cycles <= cycles + 32'd1;
        // Same expression covers both builds: blocked cycle or overwritten entry.
        if (active && full && !pop) overflow <= 1'b1;
      end
    end
  end

  trace_ring #(.W(EW), .DEPTH(DEPTH)) uRing (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (clrOk),
    .push   (cpu_en),
    .pop    (pop),
    .wrData ({pc_in, instr_in}),
    .head   (head),
    .level  (level),
    .full   (full),
    .empty  (empty)
  );

  assign rd_valid = ~empty;
  assign rd_pc    = head[EW-1 -: PC_W];
  assign rd_instr = head[INSN_W-1:0];
  assign done     = (state == S_DONE);
endmodule

// File: tb/tb_cpu_run_tracer.sv
// Scoreboard bench for cpu_run_tracer (DEPTH=4, MAX_CYCLES=15).
module tb_cpu_run_tracer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, step = 1'b0, halt_req = 1'b0, clr = 1'b0;
  logic [31:0] pc_in, instr_in;
  logic        cpu_en, rd_ready = 1'b0, rd_valid, done, overflow;
  logic [31:0] rd_pc, rd_instr, cycles;
  logic [2:0]  level;

  logic [31:0] pc = '0;
  logic [31:0] haltPc = 32'hFFFF_FFFF;
  logic        pcClr = 1'b0;
  int          total = 0, bad = 0, cpuEnCount = 0, c0;
  logic [63:0] expQ[$];

  cpu_run_tracer #(.PC_W(32), .INSN_W(32), .DEPTH(4), .MAX_CYCLES(15)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .step(step), .halt_req(halt_req), .clr(clr),
    .pc_in(pc_in), .instr_in(instr_in), .cpu_en(cpu_en), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_instr(rd_instr), .level(level),
    .cycles(cycles), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instrOf(input logic [31:0] p);
    return (p == haltPc) ? 32'hFC00_0000 : {6'd1, p[25:0]};
  endfunction

  // Toy CPU: PC advances on every committed cycle.
  always @(posedge clk) begin
    if (pcClr) pc <= '0;
    else if (cpu_en) pc <= pc + 32'd4;
  end
  assign pc_in    = pc;
  assign instr_in = instrOf(pc);

  always @(negedge clk) if (rst_n && cpu_en) cpuEnCount++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted trace entry must match the head of the scoreboard.
  always @(negedge clk) begin
    logic [63:0] e;
    if (rst_n && rd_valid && rd_ready) begin
      if (expQ.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_pop: got pc %0h expected no entry", rd_pc);
      end else begin
        e = expQ.pop_front();
        check("trace_pc", {32'd0, rd_pc}, {32'd0, e[63:32]});
        check("trace_instr", {32'd0, rd_instr}, {32'd0, e[31:0]});
      end
    end
  end

  task automatic expectPcs(input logic [31:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] p;
      p = first + 32'(4 * i);
      expQ.push_back({p, instrOf(p)});
    end
  endtask

  task automatic pulseStart();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic pulseStep();
    @(posedge clk); #1 step = 1'b1;
    @(posedge clk); #1 step = 1'b0;
  endtask

  task automatic clrAll();
    @(posedge clk); #1 clr = 1'b1; pcClr = 1'b1;
    @(posedge clk); #1 clr = 1'b0; pcClr = 1'b0;
  endtask

  task automatic waitDone(input string name);
    int n = 0;
    while (!done && n < 100) begin @(negedge clk); n++; end
    if (!done) begin total++; bad++; $display("FAIL %s: got done=0 expected done=1 within 100 cycles", name); end
  endtask

  task automatic drain(input string name);
    int n = 0;
    rd_ready = 1'b1;
    @(negedge clk);
    while (level != 0 && n < 50) begin @(negedge clk); n++; end
    if (level != 0) begin total++; bad++; $display("FAIL %s_drain: got level=%0d expected 0", name, level); end
    @(negedge clk);
    check({name, "_queue_left"}, 64'(expQ.size()), 64'd0);
  endtask

  initial begin
    // 1: reset state, then reset in the middle of a run
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_outs", {cpu_en, rd_valid, done, overflow, level, cycles}, 64'd0);
    check("rst_head", {rd_pc, rd_instr}, 64'd0);
    pulseStart();
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0; pcClr = 1'b1;
    @(negedge clk);
    check("midrun_rst_async", {cpu_en, rd_valid, done, level, cycles}, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1; pcClr = 1'b0;
    @(negedge clk);
    check("after_rst_outs", {cpu_en, rd_valid, done, overflow, level, cycles}, 64'd0);
    check("after_rst_head", {rd_pc, rd_instr}, 64'd0);

    // 2: run to the cycle budget, draining on the fly
    expectPcs(32'h0, 15);
    rd_ready = 1'b1;
    c0 = cpuEnCount;
    pulseStart();
    waitDone("budget");
    check("budget_cpu_en", 64'(cpuEnCount - c0), 64'd15);
    check("budget_cycles", {32'd0, cycles}, 64'd15);
    check("budget_done", {63'd0, done}, 64'd1);
    drain("budget");

    // 3: halt opcode at PC 0x10; start in DONE without clr is ignored
    pulseStart();
    @(negedge clk);
    check("done_start_ignored", {62'd0, done, cpu_en}, 64'd2);
    clrAll();
    @(negedge clk);
    check("clr_in_done", {31'd0, done, cycles}, 64'd0);
    haltPc = 32'h10;
    expectPcs(32'h0, 5);
    pulseStart();
    waitDone("haltop");
    check("haltop_cycles", {32'd0, cycles}, 64'd5);
    drain("haltop");
    haltPc = 32'hFFFF_FFFF;

    // 4: three single steps
    clrAll();
    rd_ready = 1'b0;
    c0 = cpuEnCount;
    for (int i = 0; i < 3; i++) begin
      pulseStep();
      repeat (2) @(posedge clk);
    end
    @(negedge clk);
    check("step_cpu_en", 64'(cpuEnCount - c0), 64'd3);
    check("step_cycles", {32'd0, cycles}, 64'd3);
    check("step_level", {61'd0, level}, 64'd3);
    check("step_idle", {62'd0, cpu_en, done}, 64'd0);
    expectPcs(32'h0, 3);
    drain("step");

    // 5: full buffer with no consumer, 6 cycles requested
    clrAll();
    rd_ready = 1'b0;
    c0 = cpuEnCount;
    pulseStart();
    repeat (5) @(posedge clk);
    #1 halt_req = 1'b1;
    @(posedge clk); #1 halt_req = 1'b0;
    @(negedge clk);
`ifdef TRACE_STALL_ON_FULL_EN
    check("full_cpu_en", 64'(cpuEnCount - c0), 64'd4);
    check("full_cycles", {32'd0, cycles}, 64'd4);
    expectPcs(32'h0, 4);
`else
    check("full_cpu_en", 64'(cpuEnCount - c0), 64'd6);
    check("full_cycles", {32'd0, cycles}, 64'd6);
    expectPcs(32'h8, 4);
`endif
    check("full_overflow", {63'd0, overflow}, 64'd1);
    check("full_level", {61'd0, level}, 64'd4);
    check("full_done", {63'd0, done}, 64'd1);
    drain("full");

    // 6: push+pop while full; clr during RUN ignored
    clrAll();
    @(negedge clk);
    check("clr_overflow", {63'd0, overflow}, 64'd0);
    rd_ready = 1'b0;
    expectPcs(32'h0, 8);
    pulseStart();
    repeat (4) @(posedge clk);
    #1 rd_ready = 1'b1; clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("pp_level", {61'd0, level}, 64'd4);
    check("pp_overflow", {63'd0, overflow}, 64'd0);
    check("pp_cycles", {32'd0, cycles}, 64'd7);
    check("pp_still_run", {62'd0, cpu_en, done}, 64'd2);
    halt_req = 1'b1;
    @(posedge clk); #1 halt_req = 1'b0;
    @(negedge clk);
    check("pp_final_cycles", {32'd0, cycles}, 64'd8);
    drain("pp");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
